// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// column drive constants and the row/column to key-code mapping.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    // Active-low one-hot column drives, and the all-released row pattern
    localparam logic [3:0] COL_0     = 4'b1110;
    localparam logic [3:0] COL_1     = 4'b1101;
    localparam logic [3:0] COL_2     = 4'b1011;
    localparam logic [3:0] COL_3     = 4'b0111;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Column index to active-low drive pattern
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = COL_0;
            2'd1:    drv = COL_1;
            2'd2:    drv = COL_2;
            2'd3:    drv = COL_3;
            default: drv = COL_0;
        endcase
        return drv;
    endfunction

    // True when exactly one row line is pulled low
    function automatic logic single_low(input logic [3:0] rows);
        logic hit;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Index of the low row line; only meaningful when single_low() holds
    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Key code = row_idx*4 + col_idx
    function automatic logic [3:0] key_to_code(input logic [1:0] row_idx,
                                               input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines. Resets to
// the released pattern so the scanner never sees a phantom press.
module row_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] row_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Two-stage capture of the raw row lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= ROWS_IDLE;
            sync_q <= ROWS_IDLE;
        end else begin
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces a single
// key press, reports its code with a one-cycle valid pulse and holds
// key_held until a debounced release.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW    = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int BW    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);
    localparam logic [BW-1:0] DEB_ONE    = BW'(1);

    logic [3:0]    row_s;
    state_e        state_q,   state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q;
    logic [DW-1:0] dwell_q,   dwell_d;
    logic [BW-1:0] deb_q,     deb_d;
    logic [3:0]    pat_q,     pat_d;
    logic [3:0]    code_q,    code_d;
    logic          valid_q,   valid_d;
    logic          held_q,    held_d;
    // armed_q stays low after reset until a full round of four columns reads
    // released, so a key held across reset is never reported.
    logic          armed_q,   armed_d;
    logic [1:0]    clean_q,   clean_d;

    row_sync u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .row_i (row),
        .row_o (row_s)
    );

    // Next-state, counter and output decisions for the scan FSM
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        pat_d     = pat_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        armed_d   = armed_q;
        clean_d   = clean_q;
        case (state_q)
            ST_SCAN: begin
                held_d = 1'b0;
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (!armed_q) begin
                        col_idx_d = col_idx_q + 2'd1;
                        if (row_s == ROWS_IDLE) begin
                            if (clean_q == 2'd3) begin
                                armed_d = 1'b1;
                                clean_d = 2'd0;
                            end else begin
                                clean_d = clean_q + 2'd1;
                            end
                        end else begin
                            clean_d = 2'd0;
                        end
                    end else if (single_low(row_s)) begin
                        // Column stays frozen while the press is qualified
                        state_d = ST_DEBOUNCE;
                        pat_d   = row_s;
                        deb_d   = '0;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (row_s == pat_q) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        code_d  = key_to_code(low_index(pat_q), col_idx_q);
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_q + DEB_ONE;
                    end
                end else begin
                    state_d   = ST_SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    deb_d     = '0;
                end
            end
            ST_PRESSED: begin
                held_d = 1'b1;
                if (row_s == ROWS_IDLE) begin
                    state_d = ST_RELEASE_WAIT;
                    deb_d   = '0;
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            ST_RELEASE_WAIT: begin
                if (row_s == ROWS_IDLE) begin
                    if (deb_q == DEB_LAST) begin
                        state_d   = ST_SCAN;
                        held_d    = 1'b0;
                        col_idx_d = col_idx_q + 2'd1;
                        dwell_d   = '0;
                        deb_d     = '0;
                    end else begin
                        deb_d = deb_q + DEB_ONE;
                    end
                end else begin
                    state_d = ST_PRESSED;
                    deb_d   = '0;
                end
            end
            default: begin
                state_d   = ST_SCAN;
                col_idx_d = 2'd0;
                dwell_d   = '0;
                deb_d     = '0;
                held_d    = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            col_q     <= COL_0;
            dwell_q   <= '0;
            deb_q     <= '0;
            pat_q     <= ROWS_IDLE;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            armed_q   <= 1'b0;
            clean_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_drive(col_idx_d);
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            pat_q     <= pat_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            armed_q   <= armed_d;
            clean_q   <= clean_d;
        end
    end

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a switch-matrix model drives the rows
// from the pressed-key set, stimulus pushes expected key codes into a queue
// and an independent monitor pops them on every key_valid pulse.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = 16'd0;     // pressed switches, index row*4+col
    logic [3:0]  exp_q[$];
    logic [3:0]  last_code = 4'd0;
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Switch matrix: a row reads low if any pressed key sits in a driven column
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
    end

    function automatic logic [3:0] drv(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each pulse and watches invariants
    always @(negedge clk) begin
        logic [3:0] exp_code;
        if (rst === 1'b1) begin
            chk("col_onehot", $countones(~col) == 1, 1);
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_code = exp_q.pop_front();
                    chk("key_code", key_code, exp_code);
                    last_code = exp_code;
                end
                chk("valid_width", prev_valid, 0);
            end
            chk("code_hold", key_code, last_code);
        end
        prev_valid = key_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input int idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col === drv(idx)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_col", ok, 1);
    endtask

    // Press a key just after its column has been left, then time acceptance
    task automatic press_start(input int r, input int c);
        bit ok;
        int cnt;
        wait_col((c + 1) % 4);
        tick();
        keys[r*4+c] = 1'b1;
        exp_q.push_back(4'(r*4 + c));
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (col === drv(c)) cnt++;
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("press_seen", ok, 1);
        chk("press_latency", cnt, SCAN_DIV + DEBOUNCE_CNT + 1);
        chk("held_on_accept", key_held, 1);
    endtask

    // Release a key and time the debounced drop of key_held
    task automatic release_key(input int r, input int c);
        bit dropped;
        int n;
        tick();
        keys[r*4+c] = 1'b0;
        n = 0;
        dropped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (key_held === 1'b0) begin
                dropped = 1'b1;
                break;
            end
        end
        chk("release_seen", dropped, 1);
        chk("release_latency", n, 3 + DEBOUNCE_CNT);
        chk("col_after_release", col, drv((c + 1) % 4));
    endtask

    task automatic press_clean(input int r, input int c, input int hold);
        press_start(r, c);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        chk("held_during_press", key_held, 1);
        release_key(r, c);
    endtask

    initial begin
        logic [3:0] seen;
        int r;
        int c;
        int hold;
        int gap;

        // Reset and the basic column walk
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("rst_col", col, 4'b1110);
                chk("rst_valid", key_valid, 0);
                chk("rst_held", key_held, 0);
                chk("rst_code", key_code, 0);
            end
            chk("col_walk", col, drv((k / SCAN_DIV) % 4));
        end
        repeat (20) tick();

        // Clean press row1/col2
        press_clean(1, 2, 40);
        repeat (10) tick();

        // Bouncy press: toggles every 3 cycles
        seen = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            tick();
            keys[6] = (((i / 3) % 2) == 0);
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (col === drv(k)) seen[k] = 1'b1;
        end
        tick();
        keys[6] = 1'b0;
        chk("bounce_col_moves", $countones(seen) >= 3, 1);
        repeat (30) tick();

        // Two keys in one column
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        repeat (60) tick();
        chk("two_key_held", key_held, 0);
        keys[0] = 1'b0;
        keys[4] = 1'b0;
        repeat (30) tick();

        // Long hold with a short release glitch
        press_start(2, 3);
        repeat (200) tick();
        keys[11] = 1'b0;
        repeat (3) tick();
        keys[11] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("held_through_glitch", key_held, 1);
        end
        release_key(2, 3);
        repeat (10) tick();

        // Reset in the middle of a debounce with the key kept down
        wait_col(2);
        tick();
        keys[9] = 1'b1;
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 40 && cnt < SCAN_DIV + 2; i++) begin
                @(negedge clk);
                if (col === drv(1)) cnt++;
                else cnt = 0;
            end
            chk("frozen_before_reset", cnt, SCAN_DIV + 2);
        end
        tick();
        rst = 1'b0;
        last_code = 4'd0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_code", key_code, 0);
        repeat (100) tick();
        chk("held_across_reset", key_held, 0);
        keys[9] = 1'b0;
        repeat (40) tick();
        press_clean(2, 1, 40);
        repeat (10) tick();

        // Sequential corner keys
        press_clean(0, 0, 40);
        repeat (10) tick();
        press_clean(3, 3, 40);
        repeat (10) tick();

        // Randomized presses
        for (int t = 0; t < 8; t++) begin
            r    = $urandom_range(3);
            c    = $urandom_range(3);
            hold = $urandom_range(40, 80);
            gap  = $urandom_range(5, 25);
            press_clean(r, c, hold);
            repeat (gap) tick();
        end

        repeat (20) tick();
        chk("pending_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each column is driven before advancing.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20: consecutive agreeing samples required to accept a press or release.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 row  input  4  keypad row lines; pulled up, a pressed key in the driven column reads 0.
REQ-006 col  output  4  column drive; one-hot active-low.
REQ-007 key_code  output  4  code of the last accepted key; code = row_idx*4 + col_idx.
REQ-008 key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 Row SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized value, adding 2 cycles of input latency.
REQ-011 The FSM SHALL have four states: SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT.
REQ-012 SCAN behaviour:
- col SHALL cycle 1110 -> 1101 -> 1011 -> 0111 -> 1110, with each column driven for SCAN_DIV cycles.
- Synchronized row SHALL be sampled on the last dwell cycle of each column.
REQ-013 SCAN -> DEBOUNCE when the sample has exactly one 0 bit; col SHALL then freeze and the debounce counter SHALL clear.
REQ-014 A sample with two or more 0 bits SHALL be treated as no key; scanning SHALL continue.
REQ-015 DEBOUNCE behaviour:
- Each cycle the row SHALL be compared with the captured pattern.
- After DEBOUNCE_CNT consecutive matches, the FSM SHALL go to PRESSED, latch key_code, and pulse key_valid for exactly one cycle.
REQ-016 Any mismatch in DEBOUNCE SHALL return the FSM to SCAN, advance to the next column, and produce no pulse.
REQ-017 PRESSED behaviour: key_held=1, no further key_valid; the FSM SHALL go to RELEASE_WAIT when row==1111.
REQ-018 RELEASE_WAIT behaviour:
- After DEBOUNCE_CNT consecutive row==1111 cycles, key_held SHALL drop, the FSM SHALL return to SCAN and advance to the next column.
- Any row!=1111 SHALL return the FSM to PRESSED.
REQ-019 key_code SHALL hold its value until the next accepted key.
REQ-020 Dwell and debounce counters SHALL be sized with $clog2 of their parameter, SHALL saturate, and SHALL never wrap into a false expiry.
REQ-021 col SHALL always be exactly one-hot-low, including during state transitions.

Reset
REQ-022 When rst==0 at a clock edge, the following SHALL take effect on that edge, including mid-debounce and mid-press:
- col=1110, key_code=0, key_valid=0, key_held=0.
- Synchronizer flops = 1111, all counters = 0, state = SCAN.
REQ-023 No key_valid SHALL be emitted for a press that was in progress at reset until it is released and pressed again after reset.

Structure
REQ-024 A shared package keypad_pkg SHALL hold the state encodings, the column one-hot constants and the row_idx/col_idx-to-code mapping.
REQ-025 The synchronizer SHALL be a sub-module named row_sync, 4 bits wide, with reset value 1111.
REQ-026 The FSM and counters SHALL reside in keypad_scan, which feeds key_code/key_valid to the answer-entry and mark stage downstream.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-027 Clean press row1/col2 (row=1101 while col=1011, held 40 cycles):
- key_code=4'h6, one key_valid pulse, key_held=1 until release.
- After release, scanning resumes at col=0111.
REQ-028 Bouncy press: row toggles 1101/1111 every 3 cycles for 30 cycles -> no key_valid, col keeps cycling.
REQ-029 Two keys in one column (row=1100 while col=1110) -> no key_valid, key_code unchanged.
REQ-030 Held key 200 cycles, then 3-cycle release glitch, then held again -> exactly one key_valid, key_held stays 1.
REQ-031 rst=0 for one cycle mid-DEBOUNCE -> next cycle col=1110, all outputs 0, no pulse while the key stays held.
REQ-032 Sequential presses row0/col0 then row3/col3 -> key_code 4'h0 then 4'hF, with exactly two key_valid pulses.
